frac_clk_div: RTL and testbench

Parametrised fractional clock-enable divider. Produces an output of average period `div_int + div_frac/2^FRAC_W` input-clock cycles by dithering each period between `div_int` and `div_int+1` cycles with a phase accumulator. Divisor and duty mode are runtime-programmable, and updates are applied glitch-free at period boundaries. It is the programmable successor to the team's fixed two/three mixed-modulus divider, and feeds baud/sample-rate enables in the same clock domain.

---
 rtl/frac_clk_div.sv | 157 +++++++++++++++
 tb/tb_frac_clk_div.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/frac_clk_div.sv
// frac_clk_div
//   Fractional clock-enable divider. Each output period lasts either div_int
//   or div_int+1 clk cycles. A phase accumulator picks which one, so the
//   average period is div_int + div_frac/2^FRAC_W cycles. A new divisor and
//   duty mode are held in a shadow copy and take effect only at a period
//   boundary, or right away while the divider is disabled. This keeps every
//   emitted period whole.
//
// Ports
//   clk      in   single clock
//   rst      in   asynchronous active-high reset
//   en       in   run enable; while low the outputs are held at 0
//   load     in   one-cycle strobe capturing div_int/div_frac/mode
//   div_int  in   integer divisor (values below 2 are rejected)
//   div_frac in   fractional divisor, LSB = 2^-FRAC_W cycle
//   mode     in   duty mode to load (0 = pulse, 1 = ~50 %)
//   clk_out  out  divided output, registered
//   tick     out  one-cycle pulse on the last cycle of every period
//   upd_pend out  a loaded configuration is waiting for a boundary
//   cfg_err  out  one-cycle pulse after a rejected load
module frac_clk_div #(
  parameter int INT_W    = 8,
  parameter int FRAC_W   = 8,
  parameter int DEF_INT  = 2,
  parameter int DEF_FRAC = 0,
  parameter bit DEF_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              mode,
  output logic              clk_out,
  output logic              tick,
  output logic              upd_pend,
  output logic              cfg_err
);

  localparam int LW = INT_W + 1;

  logic [INT_W-1:0]  act_int, act_int_n;
  logic [FRAC_W-1:0] act_frac, act_frac_n;
  logic              act_mode, act_mode_n;
  logic [INT_W-1:0]  sh_int, sh_int_n;
  logic [FRAC_W-1:0] sh_frac, sh_frac_n;
  logic              sh_mode, sh_mode_n;
  logic              pend, pend_n;
  logic [FRAC_W-1:0] acc, acc_n;
  logic [LW-1:0]     cnt, cnt_n;
  logic [LW-1:0]     cur_len, cur_len_n;

  logic              boundary;
  logic              apply;
  logic              load_ok;
  logic [FRAC_W:0]   acc_sum;
  logic              tick_n;
  logic              high_n;
  logic              clk_out_n;

  assign boundary = en && (cnt == (cur_len - LW'(1)));
  // While disabled, a pending update is applied at once, because no period
  // is in progress.
  assign apply    = pend && (!en || boundary);
  assign load_ok  = load && (div_int >= INT_W'(2));
  assign acc_sum  = {1'b0, acc} + {1'b0, act_frac};

  always_comb begin
    act_int_n  = act_int;
    act_frac_n = act_frac;
    act_mode_n = act_mode;
    acc_n      = acc;
    cur_len_n  = cur_len;

    // Clearing cnt while disabled makes a resume start a fresh, full-length
    // period. acc and cur_len hold, so the dither sequence continues.
    if (!en || boundary) begin
      cnt_n = '0;
    end else begin
      cnt_n = cnt + LW'(1);
    end

    if (apply) begin
      act_int_n  = sh_int;
      act_frac_n = sh_frac;
      act_mode_n = sh_mode;
      acc_n      = '0;
      cur_len_n  = {1'b0, sh_int};
    end else if (boundary) begin
      acc_n     = acc_sum[FRAC_W-1:0];
      cur_len_n = {1'b0, act_int} + LW'(acc_sum[FRAC_W]);
    end
  end

  // A load in the same cycle as an apply wins over the clear. The apply
  // itself uses the registered (pre-load) shadow.
  always_comb begin
    sh_int_n  = sh_int;
    sh_frac_n = sh_frac;
    sh_mode_n = sh_mode;
    pend_n    = pend;
    if (load_ok) begin
      sh_int_n  = div_int;
      sh_frac_n = div_frac;
      sh_mode_n = mode;
      pend_n    = 1'b1;
    end else if (apply) begin
      pend_n = 1'b0;
    end
  end

  // The outputs are decoded from next-state, so each registered output
  // matches the cnt/cur_len of the cycle in which it is visible.
  // cur_len - floor(cur_len/2) is the high time in mode 1; odd lengths get
  // the extra cycle high.
  always_comb begin
    tick_n    = (cnt_n == (cur_len_n - LW'(1)));
    high_n    = (cnt_n < (cur_len_n - (cur_len_n >> 1)));
    clk_out_n = act_mode_n ? high_n : tick_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_int  <= INT_W'(DEF_INT);
      act_frac <= FRAC_W'(DEF_FRAC);
      act_mode <= DEF_MODE;
      sh_int   <= INT_W'(DEF_INT);
      sh_frac  <= FRAC_W'(DEF_FRAC);
      sh_mode  <= DEF_MODE;
      pend     <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      cur_len  <= LW'(DEF_INT);
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      act_int  <= act_int_n;
      act_frac <= act_frac_n;
      act_mode <= act_mode_n;
      sh_int   <= sh_int_n;
      sh_frac  <= sh_frac_n;
      sh_mode  <= sh_mode_n;
      pend     <= pend_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      cur_len  <= cur_len_n;
      clk_out  <= en && clk_out_n;
      tick     <= en && tick_n;
      cfg_err  <= load && !load_ok;
    end
  end

  assign upd_pend = pend;

endmodule

// File: tb/tb_frac_clk_div.sv
module tb_frac_clk_div;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] div_int = 8'd0;
  logic [7:0] div_frac = 8'd0;
  logic       mode = 1'b0;
  logic       clk_out, tick, upd_pend, cfg_err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: per-period view. m_pos is the position inside the
  // current period and m_len is that period's length. m_k counts the periods
  // completed since the last apply. The length of each period comes from
  // floor(k*F/256) differences, with no accumulator register.
  int m_pos, m_len, m_k, m_int, m_frac, m_mode;
  int s_int, s_frac, s_mode;
  bit m_pend, m_prev_en, m_err;

  frac_clk_div #(.INT_W(8), .FRAC_W(8), .DEF_INT(2), .DEF_FRAC(0), .DEF_MODE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_int(div_int),
    .div_frac(div_frac), .mode(mode), .clk_out(clk_out), .tick(tick),
    .upd_pend(upd_pend), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mreset();
    m_pos = 0; m_len = 2; m_k = 0; m_int = 2; m_frac = 0; m_mode = 0;
    s_int = 2; s_frac = 0; s_mode = 0; m_pend = 0; m_prev_en = 0; m_err = 0;
  endtask

  function automatic int frac_floor(int k, int f);
    return (k * f) / 256;
  endfunction

  task automatic model_edge();
    bit bnd, app;
    bnd = en && (m_pos == m_len - 1);
    app = m_pend && (!en || bnd);
    if (!en || bnd) m_pos = 0;
    else m_pos++;
    if (app) begin
      m_int = s_int; m_frac = s_frac; m_mode = s_mode;
      m_k = 0; m_len = m_int; m_pend = 0;
    end else if (bnd) begin
      m_k++;
      m_len = m_int + frac_floor(m_k, m_frac) - frac_floor(m_k - 1, m_frac);
    end
    m_err = 0;
    if (load) begin
      if (div_int >= 2) begin
        s_int = div_int; s_frac = div_frac; s_mode = mode; m_pend = 1;
      end else begin
        m_err = 1;
      end
    end
    m_prev_en = en;
  endtask

  task automatic step();
    bit e_tick, e_clk;
    @(posedge clk);
    model_edge();
    #1;
    e_tick = m_prev_en && (m_pos == m_len - 1);
    e_clk  = m_prev_en && (m_mode != 0 ? (m_pos < (m_len + 1) / 2) : (m_pos == m_len - 1));
    chk("tick", tick, e_tick);
    chk("clk_out", clk_out, e_clk);
    chk("upd_pend", upd_pend, m_pend);
    chk("cfg_err", cfg_err, m_err);
  endtask

  task automatic do_load(input int i, input int f, input int md);
    load = 1; div_int = 8'(i); div_frac = 8'(f); mode = md[0];
    step();
    load = 0;
  endtask

  task automatic wait_apply();
    int n;
    n = 0;
    while (upd_pend && n < 60) begin
      step();
      n++;
    end
    chk("apply_timeout", upd_pend, 0);
  endtask

  task automatic meas(input int start, output int n);
    n = start;
    do begin
      step();
      n++;
    end while (!tick && n < 60);
  endtask

  initial begin
    int n;
    int exp_len[8] = '{3, 3, 3, 3, 4, 3, 3, 3};
    bit pat5[5] = '{1, 1, 1, 0, 0};
    mreset();
    #12;
    chk("rst_tick", tick, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_upd_pend", upd_pend, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    rst = 0; en = 1;

    // Defaults: tick in cycles 2, 4, 6 after release.
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) step();
      chk("def_tick", tick, (c % 2 == 0) ? 1 : 0);
    end

    // 3 + 0x40/256.
    do_load(3, 8'h40, 0);
    wait_apply();
    meas(1, n);
    chk("frac_len", n, exp_len[0]);
    for (int p = 1; p < 8; p++) begin
      meas(0, n);
      chk("frac_len", n, exp_len[p]);
    end

    // 5, mode 1.
    do_load(5, 0, 1);
    wait_apply();
    for (int c = 0; c < 10; c++) begin
      chk("m1_clk", clk_out, pat5[c % 5]);
      chk("m1_tick", tick, (c % 5 == 4) ? 1 : 0);
      step();
    end

    // Rejected load.
    do_load(1, 0, 0);
    chk("err_pulse", cfg_err, 1);
    chk("err_no_pend", upd_pend, 0);
    step();
    chk("err_clear", cfg_err, 0);

    // Load mid-period, then a second load on the boundary cycle.
    do_load(3, 0, 0);
    wait_apply();
    step();
    do_load(4, 0, 0);
    n = 0;
    while (!(m_pos == m_len - 1) && n < 20) begin
      step();
      n++;
    end
    do_load(6, 0, 0);
    chk("pend_still", upd_pend, 1);
    meas(1, n);
    chk("len_after_4", n, 4);
    meas(0, n);
    chk("len_after_6", n, 6);

    // Reset during a mode-1 high phase.
    do_load(5, 0, 1);
    wait_apply();
    n = 0;
    while (!clk_out && n < 20) begin
      step();
      n++;
    end
    rst = 1;
    #1;
    chk("async_clk_out", clk_out, 0);
    chk("async_tick", tick, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    mreset();
    for (int c = 0; c < 6; c++) step();

    // Disable for 10 cycles.
    en = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("dis_tick", tick, 0);
    end
    en = 1;
    meas(1, n);
    chk("resume_len", n, 2);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 19) != 0);
      load = ($urandom_range(0, 11) == 0);
      div_int = 8'($urandom_range(0, 7));
      div_frac = 8'($urandom_range(0, 255));
      mode = 1'($urandom_range(0, 1));
      step();
    end
    load = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
